// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decoder state type and game key indices.
// Imported by the key decoder, its code map and top_game.
package ps2_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_AA    = 8'hAA;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   localparam int KEY_LEFT  = 0;
   localparam int KEY_RIGHT = 1;
   localparam int KEY_UP    = 2;
   localparam int KEY_DOWN  = 3;

   // Extended sources sit four bits above their WASD twins.
   localparam int EXT_OFS = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_t;

endpackage

// File: rtl/ps2_code_map.sv
// Maps an (extended flag, scan byte) pair onto a held-source index.
// Purely combinational; o_hit is low for unmapped codes.
module ps2_code_map
   import ps2_pkg::*;
(
   input  logic       i_ext,
   input  logic [7:0] i_code,
   output logic       o_hit,
   output logic [2:0] o_idx
);

   always_comb begin
      o_hit = 1'b1;
      o_idx = 3'd0;
      case ({i_ext, i_code})
         {1'b0, SC_A}:     o_idx = 3'(KEY_LEFT);
         {1'b0, SC_D}:     o_idx = 3'(KEY_RIGHT);
         {1'b0, SC_W}:     o_idx = 3'(KEY_UP);
         {1'b0, SC_S}:     o_idx = 3'(KEY_DOWN);
         {1'b1, SC_LEFT}:  o_idx = 3'(KEY_LEFT + EXT_OFS);
         {1'b1, SC_RIGHT}: o_idx = 3'(KEY_RIGHT + EXT_OFS);
         {1'b1, SC_UP}:    o_idx = 3'(KEY_UP + EXT_OFS);
         {1'b1, SC_DOWN}:  o_idx = 3'(KEY_DOWN + EXT_OFS);
         default:          o_hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the PS/2 scan-code byte stream into the held game-key vector,
// handling E0/F0 prefixes, key-rise pulses and prefix timeouts.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 500_000,
   parameter int CNT_W       = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ps2_data,
   input  logic       ps2_valid,
   output logic [3:0] key,
   output logic [3:0] key_rise,
   output logic       seq_err
);

   ps2_state_t       r_state;
   logic [7:0]       r_held;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_key;
   logic [3:0]       r_key_rise;
   logic             r_seq_err;

   logic       w_ext;
   logic       w_hit;
   logic [2:0] w_idx;
   logic       w_is_e0;
   logic       w_is_f0;
   logic       w_is_aa;
   logic [3:0] w_key_next;
   logic       w_tmo;

   assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

   ps2_code_map u_map (
      .i_ext  (w_ext),
      .i_code (ps2_data),
      .o_hit  (w_hit),
      .o_idx  (w_idx)
   );

   assign w_is_e0    = (ps2_data == SC_E0);
   assign w_is_f0    = (ps2_data == SC_F0);
   assign w_is_aa    = (ps2_data == SC_AA);
   assign w_key_next = r_held[3:0] | r_held[7:4];
   assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_held     <= '0;
         r_cnt      <= '0;
         r_key      <= '0;
         r_key_rise <= '0;
         r_seq_err  <= 1'b0;
      end else begin
         r_seq_err  <= 1'b0;
         r_key      <= w_key_next;
         r_key_rise <= w_key_next & ~r_key;
         if (ps2_valid) begin
            r_cnt <= '0;
            unique case (r_state)
               ST_IDLE: begin
                  unique case (1'b1)
                     w_is_e0: r_state <= ST_EXT;
                     w_is_f0: r_state <= ST_BRK;
                     w_is_aa: r_held  <= '0;
                     w_hit:   r_held[w_idx] <= 1'b1;
                     default: ;
                  endcase
               end
               ST_EXT: begin
                  unique case (1'b1)
                     w_is_f0: r_state <= ST_EXT_BRK;
                     w_is_e0: r_seq_err <= 1'b1;
                     w_hit: begin
                        r_held[w_idx] <= 1'b1;
                        r_state       <= ST_IDLE;
                     end
                     default: r_state <= ST_IDLE;
                  endcase
               end
               ST_BRK: begin
                  r_state <= ST_IDLE;
                  if (w_hit)
                     r_held[w_idx] <= 1'b0;
                  else if (w_is_e0 || w_is_f0)
                     r_seq_err <= 1'b1;
               end
               ST_EXT_BRK: begin
                  r_state <= ST_IDLE;
                  if (w_hit)
                     r_held[w_idx] <= 1'b0;
               end
            endcase
         end else if (r_state != ST_IDLE) begin
            // A stalled prefix is dropped; held keys survive the abort.
            if (w_tmo) begin
               r_state   <= ST_IDLE;
               r_seq_err <= 1'b1;
               r_cnt     <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign key      = r_key;
   assign key_rise = r_key_rise;
   assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random byte streams
// compared cycle by cycle against a prefix-flag reference model.
module tb_ps2_key_decoder;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_valid = 1'b0;
   logic [3:0] key;
   logic [3:0] key_rise;
   logic       seq_err;

   int n_chk = 0;
   int n_err = 0;
   int rise2_cnt = 0;

   bit         m_held [8];
   bit         m_ext;
   bit         m_brk;
   int         m_idle;
   logic [3:0] m_key;
   logic [3:0] m_rise;
   logic       m_err;

   logic [7:0] codes [8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B,
                             8'h6B, 8'h74, 8'h75, 8'h72};

   ps2_key_decoder #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_data  (ps2_data),
      .ps2_valid (ps2_valid),
      .key       (key),
      .key_rise  (key_rise),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int map_idx(bit ext, logic [7:0] b);
      int lo = ext ? 4 : 0;
      for (int i = lo; i < lo + 4; i++)
         if (codes[i] == b) return i;
      return -1;
   endfunction

   function automatic logic [3:0] held_keys();
      logic [3:0] k;
      for (int i = 0; i < 4; i++) k[i] = m_held[i] | m_held[i+4];
      return k;
   endfunction

   task automatic model_edge(input logic v, input logic [7:0] d,
                             input logic r);
      logic [3:0] kn;
      int         ix;
      kn     = held_keys();
      m_err  = 1'b0;
      if (r) begin
         foreach (m_held[i]) m_held[i] = 1'b0;
         m_ext = 0; m_brk = 0; m_idle = 0;
         m_key = '0; m_rise = '0;
         return;
      end
      m_rise = kn & ~m_key;
      m_key  = kn;
      if (v) begin
         m_idle = 0;
         ix = map_idx(m_ext, d);
         if (!m_ext && !m_brk) begin
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hAA) foreach (m_held[i]) m_held[i] = 1'b0;
            else if (ix >= 0) m_held[ix] = 1'b1;
         end else if (m_ext && !m_brk) begin
            if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hE0) m_err = 1'b1;
            else begin
               if (ix >= 0) m_held[ix] = 1'b1;
               m_ext = 0;
            end
         end else if (!m_ext) begin
            if (ix >= 0) m_held[ix] = 1'b0;
            else if (d == 8'hE0 || d == 8'hF0) m_err = 1'b1;
            m_brk = 0;
         end else begin
            if (ix >= 0) m_held[ix] = 1'b0;
            m_ext = 0; m_brk = 0;
         end
      end else if (m_ext || m_brk) begin
         m_idle++;
         if (m_idle == TO) begin
            m_ext = 0; m_brk = 0; m_idle = 0;
            m_err = 1'b1;
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic r);
      ps2_valid = v;
      ps2_data  = d;
      rst       = r;
      @(posedge clk);
      model_edge(v, d, r);
      @(negedge clk);
      rise2_cnt += int'(key_rise[2]);
      chk("key", {4'h0, key}, {4'h0, m_key});
      chk("key_rise", {4'h0, key_rise}, {4'h0, m_rise});
      chk("seq_err", {7'h0, seq_err}, {7'h0, m_err});
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
   endtask

   function automatic logic [7:0] pick_byte();
      int sel = $urandom_range(0, 9);
      if (sel < 2) return 8'hE0;
      if (sel < 4) return 8'hF0;
      if (sel == 4) return ($urandom_range(0, 7) == 0) ? 8'hAA : 8'h00;
      if (sel < 9) return codes[$urandom_range(0, 7)];
      return 8'($urandom);
   endfunction

   initial begin
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("reset_key", {4'h0, key}, 8'h00);

      // 1: A make/break
      send(8'h1C); idle(1);
      chk("t1_key", {4'h0, key}, 8'h01);
      chk("t1_rise", {4'h0, key_rise}, 8'h01);
      idle(1);
      send(8'hF0); send(8'h1C); idle(2);
      chk("t1_brk", {4'h0, key}, 8'h00);

      // 2: right arrow and bare 74
      send(8'hE0); send(8'h74); idle(1);
      chk("t2_set", {4'h0, key}, 8'h02);
      send(8'hE0); send(8'hF0); send(8'h74); idle(2);
      chk("t2_clr", {4'h0, key}, 8'h00);
      send(8'h74); idle(2);
      chk("t2_bare", {4'h0, key}, 8'h00);

      // 3: W and up both held, one released
      rise2_cnt = 0;
      send(8'h1D); send(8'hE0); send(8'h75); idle(2);
      send(8'hF0); send(8'h1D); idle(2);
      chk("t3_hold", {7'h0, key[2]}, 8'h01);
      chk("t3_rise_cnt", 8'(rise2_cnt), 8'h01);
      send(8'hE0); send(8'hF0); send(8'h75); idle(2);
      chk("t3_clr", {4'h0, key}, 8'h00);

      // 4: prefix timeout
      send(8'hE0); idle(TO - 1);
      chk("t4_pre", {7'h0, seq_err}, 8'h00);
      idle(1);
      chk("t4_err", {7'h0, seq_err}, 8'h01);
      send(8'h6B); idle(2);
      chk("t4_6b", {4'h0, key}, 8'h00);

      // 5: AA clears everything
      send(8'h1C); send(8'h23); idle(2);
      chk("t5_held", {4'h0, key}, 8'h03);
      send(8'hAA); idle(1);
      chk("t5_clr", {4'h0, key}, 8'h00);
      chk("t5_noerr", {7'h0, seq_err}, 8'h00);

      // 6: reset beats a same-cycle byte
      cycle(1'b1, 8'h1C, 1'b1);
      idle(2);
      chk("t6_key", {4'h0, key}, 8'h00);
      send(8'hF0); send(8'h1C); idle(2);
      chk("t6_after", {4'h0, key}, 8'h00);

      // Random streams, with gaps long enough to hit timeouts.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0)
            cycle($urandom_range(0, 1) == 1, pick_byte(), 1'b1);
         else if ($urandom_range(0, 99) == 0)
            idle($urandom_range(TO - 2, TO + 2));
         else if ($urandom_range(0, 2) != 0)
            send(pick_byte());
         else
            idle(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
